// File: rtl/memory_manager.sv
// Single owner of the external 128K x 8 asynchronous SRAM.
// Video scan-out owns the RAM during active pixels; the MCU port gets single-byte accesses otherwise.
module memory_manager #(
    parameter logic [2:0] STATE_ACTIVE      = 3'd0,
    parameter logic [2:0] STATE_FRONT_PORCH = 3'd1,
    parameter logic [2:0] STATE_SYNC        = 3'd2,
    parameter logic [2:0] STATE_BACK_PORCH  = 3'd3,
    parameter logic [2:0] STATE_VBLANK      = 3'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  currentState,
    input  logic [8:0]  videoAddress,
    output logic [7:0]  videoData,
    output logic        videoDataReady,
    input  logic [16:0] memoryAddress,
    input  logic        memoryReadRequest,
    input  logic        memoryWriteRequest,
    output logic [7:0]  memoryReadData,
    input  logic [7:0]  memoryWriteData,
    output logic        memoryWriteComplete,
    output logic        memoryReadComplete,
    output logic [16:0] ramAddress,
    inout  wire  [7:0]  ramData,
    output logic        ramOutputEnable,
    output logic        ramWriteEnable
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        RD_SETUP,
        RD_SAMPLE,
        DONE,
        VIDEO
    } mcu_state_t;

    mcu_state_t  state;
    logic [7:0]  line_counter;
    logic        was_active;
    logic        done_write;
    logic        drive_en;
    logic [7:0]  drive_data;
    logic        is_active;
    logic        mcu_phase;
    logic [16:0] video_addr;

    assign is_active  = (currentState == STATE_ACTIVE);
    assign mcu_phase  = (currentState == STATE_FRONT_PORCH) || (currentState == STATE_SYNC) ||
                        (currentState == STATE_BACK_PORCH)  || (currentState == STATE_VBLANK);
    assign video_addr = {line_counter, videoAddress};
    assign ramData    = drive_en ? drive_data : 8'hzz;

    // Video fetch pipeline, line counter and the MCU access sequencer share one register block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            ramAddress          <= '0;
            ramWriteEnable      <= 1'b1;
            ramOutputEnable     <= 1'b1;
            drive_en            <= 1'b0;
            drive_data          <= '0;
            videoData           <= '0;
            videoDataReady      <= 1'b0;
            memoryReadData      <= '0;
            memoryWriteComplete <= 1'b0;
            memoryReadComplete  <= 1'b0;
            line_counter        <= '0;
            was_active          <= 1'b0;
            done_write          <= 1'b0;
        end else begin
            memoryWriteComplete <= 1'b0;
            memoryReadComplete  <= 1'b0;
            was_active          <= is_active;
            videoDataReady      <= was_active;

            // The bus carries the byte for last cycle's video address.
            if (was_active)
                videoData <= ramData;

            if (currentState == STATE_VBLANK)
                line_counter <= '0;
            else if (was_active && !is_active)
                line_counter <= line_counter + 8'd1;

            if (is_active) begin
                state           <= VIDEO;
                ramAddress      <= video_addr;
                ramOutputEnable <= 1'b0;
                ramWriteEnable  <= 1'b1;
                drive_en        <= 1'b0;
            end else begin
                case (state)
                    VIDEO: begin
                        state           <= IDLE;
                        ramOutputEnable <= 1'b1;
                        ramWriteEnable  <= 1'b1;
                        drive_en        <= 1'b0;
                    end
                    IDLE: begin
                        if (mcu_phase && memoryWriteRequest) begin
                            state           <= WR_SETUP;
                            ramAddress      <= memoryAddress;
                            drive_data      <= memoryWriteData;
                            drive_en        <= 1'b1;
                            ramWriteEnable  <= 1'b1;
                            ramOutputEnable <= 1'b1;
                        end else if (mcu_phase && memoryReadRequest) begin
                            state           <= RD_SETUP;
                            ramAddress      <= memoryAddress;
                            drive_en        <= 1'b0;
                            ramWriteEnable  <= 1'b1;
                            ramOutputEnable <= 1'b0;
                        end
                    end
                    WR_SETUP: begin
                        state          <= WR_STROBE;
                        ramWriteEnable <= 1'b0;
                    end
                    WR_STROBE: begin
                        state               <= DONE;
                        ramWriteEnable      <= 1'b1;
                        memoryWriteComplete <= 1'b1;
                        done_write          <= 1'b1;
                    end
                    RD_SETUP: begin
                        state           <= RD_SAMPLE;
                        memoryReadData  <= ramData;
                        ramOutputEnable <= 1'b0;
                    end
                    RD_SAMPLE: begin
                        state              <= DONE;
                        ramOutputEnable    <= 1'b1;
                        memoryReadComplete <= 1'b1;
                        done_write         <= 1'b0;
                    end
                    DONE: begin
                        // Wait for the client to drop the finished request so it is not issued twice.
                        drive_en <= 1'b0;
                        if (done_write ? !memoryWriteRequest : !memoryReadRequest)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_manager.sv
// Scoreboard bench for memory_manager with a behavioural asynchronous SRAM model.
module tb_memory_manager;

    localparam logic [2:0] ACTIVE = 3'd0;
    localparam logic [2:0] FRONT  = 3'd1;
    localparam logic [2:0] VBLANK = 3'd4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  currentState;
    logic [8:0]  videoAddress;
    logic [7:0]  videoData;
    logic        videoDataReady;
    logic [16:0] memoryAddress;
    logic        memoryReadRequest;
    logic        memoryWriteRequest;
    logic [7:0]  memoryReadData;
    logic [7:0]  memoryWriteData;
    logic        memoryWriteComplete;
    logic        memoryReadComplete;
    logic [16:0] ramAddress;
    wire  [7:0]  ramData;
    logic        ramOutputEnable;
    logic        ramWriteEnable;

    memory_manager dut (
        .clock(clock),
        .reset(reset),
        .currentState(currentState),
        .videoAddress(videoAddress),
        .videoData(videoData),
        .videoDataReady(videoDataReady),
        .memoryAddress(memoryAddress),
        .memoryReadRequest(memoryReadRequest),
        .memoryWriteRequest(memoryWriteRequest),
        .memoryReadData(memoryReadData),
        .memoryWriteData(memoryWriteData),
        .memoryWriteComplete(memoryWriteComplete),
        .memoryReadComplete(memoryReadComplete),
        .ramAddress(ramAddress),
        .ramData(ramData),
        .ramOutputEnable(ramOutputEnable),
        .ramWriteEnable(ramWriteEnable)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int readyCycles = 0;
    int weLowCycles = 0;
    int wrCompletes = 0;
    int rdCompletes = 0;
    int wrCycle = 0;
    int rdCycle = 0;
    logic [7:0] expectedLine = 8'd0;
    logic [2:0] lastState = FRONT;

    logic [7:0]  vidQ[$];
    logic [7:0]  rdQ[$];
    logic [16:0] wrAddrQ[$];
    logic [7:0]  wrDataQ[$];

    logic [7:0] mem [0:131071];
    bit preloaded = 1'b0;

    function automatic logic [7:0] pixel(input logic [7:0] line, input logic [8:0] col);
        return {line[3:0], col[3:0]};
    endfunction

    assign ramData = (!ramOutputEnable && ramWriteEnable) ? mem[ramAddress] : 8'hzz;

    // SRAM model: preloaded on the first falling edge, then latches writes while /WE is low.
    always @(negedge clock) begin
        if (!preloaded) begin
            for (int l = 0; l < 4; l++)
                for (int c = 0; c < 16; c++)
                    mem[{l[7:0], c[8:0]}] = pixel(l[7:0], c[8:0]);
            mem[17'h00123] = 8'hA5;
            preloaded = 1'b1;
        end
        if (!reset && !ramWriteEnable)
            mem[ramAddress] = ramData;
    end

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, observed, expected, cycle);
        end
    endtask

    // Output monitor: pops the scoreboard whenever the DUT produces a result.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("oe_we_both_low", 32'(!ramOutputEnable && !ramWriteEnable), 0);
            if (videoDataReady) begin
                readyCycles++;
                if (vidQ.size() > 0) checkOutput("video_data", 32'(videoData), 32'(vidQ.pop_front()));
                else                 checkOutput("video_unexpected", 32'(vidQ.size()), 1);
            end
            if (!ramWriteEnable) begin
                weLowCycles++;
                if (wrAddrQ.size() > 0) begin
                    checkOutput("wr_address", 32'(ramAddress), 32'(wrAddrQ.pop_front()));
                    checkOutput("wr_bus", 32'(ramData), 32'(wrDataQ.pop_front()));
                end else begin
                    checkOutput("we_unexpected", 32'(wrAddrQ.size()), 1);
                end
            end
            if (memoryWriteComplete) begin
                wrCompletes++;
                wrCycle = cycle;
            end
            if (memoryReadComplete) begin
                rdCompletes++;
                rdCycle = cycle;
                if (rdQ.size() > 0) checkOutput("rd_data", 32'(memoryReadData), 32'(rdQ.pop_front()));
                else                checkOutput("rd_unexpected", 32'(rdQ.size()), 1);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] s, input logic [8:0] col);
        if (s == VBLANK)
            expectedLine = 8'd0;
        else if (lastState == ACTIVE && s != ACTIVE)
            expectedLine = expectedLine + 8'd1;
        lastState    = s;
        currentState = s;
        videoAddress = col;
    endtask

    task automatic activeCycle(input logic [8:0] col);
        @(posedge clock); #1;
        applyStimulus(ACTIVE, col);
        vidQ.push_back(pixel(expectedLine, col));
    endtask

    task automatic videoBurst(input int n, input logic [8:0] startCol, input logic [2:0] after);
        int r0;
        r0 = readyCycles;
        for (int i = 0; i < n; i++) activeCycle(startCol + 9'(i));
        @(posedge clock); #1;
        applyStimulus(after, 9'd0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("video_ready_count", 32'(readyCycles - r0), 32'(n));
        checkOutput("video_q_drained", 32'(vidQ.size()), 0);
    endtask

    task automatic startWrite(input logic [16:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        memoryAddress      = a;
        memoryWriteData    = d;
        memoryWriteRequest = 1'b1;
        wrAddrQ.push_back(a);
        wrDataQ.push_back(d);
    endtask

    task automatic startRead(input logic [16:0] a, input logic [7:0] expected);
        @(posedge clock); #1;
        memoryAddress     = a;
        memoryReadRequest = 1'b1;
        rdQ.push_back(expected);
    endtask

    // Waits for one completion, holds the request two more edges, then drops it.
    task automatic waitComplete(input bit isWrite, input int start, input bit checkLat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = isWrite ? memoryWriteComplete : memoryReadComplete;
        end
        checkOutput(isWrite ? "wr_complete_seen" : "rd_complete_seen", 32'(seen), 1);
        if (checkLat) checkOutput(isWrite ? "wr_latency" : "rd_latency", 32'(cycle - start), 3);
        @(posedge clock); #1;
        @(posedge clock); #1;
        if (isWrite) memoryWriteRequest = 1'b0;
        else         memoryReadRequest  = 1'b0;
    endtask

    initial begin
        int w0, r0, e0, start;
        applyStimulus(FRONT, 9'd0);
        memoryAddress      = '0;
        memoryWriteData    = '0;
        memoryReadRequest  = 1'b0;
        memoryWriteRequest = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_we", 32'(ramWriteEnable), 1);
        checkOutput("reset_oe", 32'(ramOutputEnable), 1);
        checkOutput("reset_wr_complete", 32'(memoryWriteComplete), 0);
        checkOutput("reset_rd_complete", 32'(memoryReadComplete), 0);
        checkOutput("reset_video_data", 32'(videoData), 0);
        checkOutput("reset_video_ready", 32'(videoDataReady), 0);
        checkOutput("reset_ram_address", 32'(ramAddress), 0);
        checkOutput("reset_rd_data", 32'(memoryReadData), 0);
        reset = 1'b0;

        // Reset in the middle of a write aborts it silently.
        w0 = wrCompletes; e0 = weLowCycles;
        @(posedge clock); #1;
        memoryAddress      = 17'h00055;
        memoryWriteData    = 8'hEE;
        memoryWriteRequest = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        memoryWriteRequest = 1'b0;
        checkOutput("abort_reset_we", 32'(ramWriteEnable), 1);
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("abort_reset_no_complete", 32'(wrCompletes - w0), 0);
        checkOutput("abort_reset_no_strobe", 32'(weLowCycles - e0), 0);

        // Plain write with request held past the complete pulse.
        w0 = wrCompletes; e0 = weLowCycles;
        startWrite(17'h101FF, 8'h03);
        start = cycle;
        waitComplete(1'b1, start, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("write_single_complete", 32'(wrCompletes - w0), 1);
        checkOutput("write_single_strobe", 32'(weLowCycles - e0), 1);

        // Read of a preloaded location, result held afterwards.
        startRead(17'h00123, 8'hA5);
        start = cycle;
        waitComplete(1'b0, start, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("read_data_held", 32'(memoryReadData), 32'hA5);

        // Two video lines; the second must come from line 1.
        videoBurst(4, 9'd0, FRONT);
        checkOutput("line_model_after_first", 32'(expectedLine), 1);
        videoBurst(4, 9'd4, FRONT);

        // Write requested one clock before ACTIVE is deferred until ACTIVE ends.
        w0 = wrCompletes; e0 = weLowCycles;
        startWrite(17'h12345, 8'hC3);
        for (int i = 0; i < 4; i++) activeCycle(9'(i + 8));
        @(posedge clock); #1;
        checkOutput("deferred_no_complete", 32'(wrCompletes - w0), 0);
        checkOutput("deferred_no_strobe", 32'(weLowCycles - e0), 0);
        applyStimulus(FRONT, 9'd0);
        waitComplete(1'b1, cycle, 1'b0);
        repeat (3) @(posedge clock);
        startRead(17'h12345, 8'hC3);
        waitComplete(1'b0, cycle, 1'b1);

        // Both requests together: the write is serviced first.
        @(posedge clock); #1;
        memoryAddress      = 17'h00AAA;
        memoryWriteData    = 8'h5C;
        memoryWriteRequest = 1'b1;
        memoryReadRequest  = 1'b1;
        wrAddrQ.push_back(17'h00AAA);
        wrDataQ.push_back(8'h5C);
        rdQ.push_back(8'h5C);
        start = cycle;
        r0 = rdCompletes;
        waitComplete(1'b1, start, 1'b1);
        waitComplete(1'b0, start, 1'b0);
        checkOutput("both_read_done", 32'(rdCompletes - r0), 1);
        checkOutput("both_write_first", 32'(wrCycle < rdCycle), 1);

        // VBLANK clears the line counter for the next frame.
        videoBurst(2, 9'd0, FRONT);
        applyStimulus(VBLANK, 9'd0);
        repeat (3) @(posedge clock);
        #1;
        applyStimulus(FRONT, 9'd0);
        checkOutput("line_model_vblank", 32'(expectedLine), 0);
        videoBurst(3, 9'd2, FRONT);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("end_rd_q_empty", 32'(rdQ.size()), 0);
        checkOutput("end_wr_q_empty", 32'(wrAddrQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
